wb_port_arbiter: RTL
====================

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 SHALL have parameter DW, default 32, register-file data width.
REQ-002 SHALL have parameter DEPTH, default 2, entries per source queue; must be a power of two, at least 2.
REQ-003 SHALL have port clk, input, 1, the only clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-005 SHALL have port alu_valid, input, 1, ALU result offered this cycle.
REQ-006 SHALL have port alu_rg, input, 4, ALU destination register.
REQ-007 SHALL have port alu_data, input, DW, ALU result.
REQ-008 SHALL have port alu_ready, output, 1, ALU queue can accept.
REQ-009 SHALL have port mem_valid, input, 1, memory load data offered this cycle.
REQ-010 SHALL have port mem_rg, input, 4, load destination register.
REQ-011 SHALL have port mem_data, input, DW, load word (Do).
REQ-012 SHALL have port mem_dob, input, 8, load byte lane.
REQ-013 SHALL have port mem_ready, output, 1, memory queue can accept.
REQ-014 SHALL have port rf_we, output, 1, register-file write strobe.
REQ-015 SHALL have port rf_rg, output, 4, write address.
REQ-016 SHALL have port rf_data, output, DW, write data.
REQ-017 SHALL have port rf_dob, output, 8, byte lane; 0 for ALU writes.
REQ-018 SHALL have port rf_src, output, 1, source of current write: 1 = mem, 0 = ALU.
REQ-019 SHALL have port stall, output, 1, upstream hold request.

Function
REQ-020 SHALL accept an entry into a source queue at a rising edge where its valid and ready are both 1 (a handshake).
REQ-021 SHALL drive x_ready = 1 only when that queue holds fewer than DEPTH entries; ready SHALL NOT depend on a same-cycle pop.
REQ-022 SHALL keep one occupancy counter per queue, width log2(DEPTH)+1: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-023 SHALL use circular read and write pointers that wrap from DEPTH-1 to 0.
REQ-024 SHALL grant at most one queue head per cycle; a grant pops that head at the next edge.
REQ-025 SHALL grant the only non-empty queue when exactly one is non-empty.
REQ-026 SHALL grant round-robin when both queues are non-empty: the source not granted last wins; the last_grant register resets to ALU, so mem wins the first contention.
REQ-027 SHALL register the granted entry onto rf_rg, rf_data, rf_dob and rf_src, and assert rf_we for exactly one cycle per popped entry.
REQ-028 SHALL drive rf_we = 0 and hold rf_rg, rf_data, rf_dob and rf_src at their previous values in cycles with no grant.
REQ-029 SHALL give latency: entry pushed at edge E into an empty, uncontended queue SHALL appear with rf_we = 1 in the cycle after edge E+1.
REQ-030 SHALL never emit entries from the same source out of push order.
REQ-031 SHALL drive stall = ~alu_ready | ~mem_ready, combinationally from the counters.
REQ-032 SHALL ignore x_rg and x_data when x_valid = 0.
REQ-033 SHALL ignore the push when x_valid = 1 and x_ready = 0; upstream must hold the data.

Reset
REQ-034 SHALL, while rst = 1, clear both counters and pointers, set last_grant = ALU, and drive rf_we = 0, rf_rg = 0, rf_data = 0, rf_dob = 0, rf_src = 0.
REQ-035 SHALL drive alu_ready = 1, mem_ready = 1 and stall = 0 after reset.
REQ-036 SHALL drop queued entries and any pending write when rst is asserted mid-operation; nothing is written after release until new pushes occur.

Verification
REQ-037 SHALL pass scenario: single ALU push (rg = 3, data = 0x0000_00AA) -> one rf_we pulse with rf_rg = 3, rf_data = 0xAA, rf_dob = 0, rf_src = 0, at the latency of REQ-029.
REQ-038 SHALL pass scenario: simultaneous ALU push (rg 1, 0x11) and mem push (rg 2, 0x22, dob 0x5C) after reset -> mem written first, then ALU next cycle.
REQ-039 SHALL pass scenario: both valid continuously for 8 cycles with DEPTH = 2 -> writes alternate mem, ALU, mem, ...; alu_ready drops once the queue holds 2 entries; stall = 1 while any queue is full; no entry lost or reordered.
REQ-040 SHALL pass scenario: mem_valid held with mem_ready = 0 -> data accepted only after ready returns; exactly one write per handshake.
REQ-041 SHALL pass scenario: rst pulsed with 2 entries queued -> immediate rf_we = 0 and all outputs 0; no writes after release.
REQ-042 SHALL pass scenario: 5 ALU pushes with DEPTH = 2 (pointer wrap) -> 5 writes in push order.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Two-source register-file write-back arbiter: per-source FIFOs for ALU results
// and memory loads, round-robin grant under contention, one registered write per cycle.
module wb_port_arbiter #(
  parameter int DW    = 32,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alu_valid,
  input  logic [3:0]    alu_rg,
  input  logic [DW-1:0] alu_data,
  output logic          alu_ready,
  input  logic          mem_valid,
  input  logic [3:0]    mem_rg,
  input  logic [DW-1:0] mem_data,
  input  logic [7:0]    mem_dob,
  output logic          mem_ready,
  output logic          rf_we,
  output logic [3:0]    rf_rg,
  output logic [DW-1:0] rf_data,
  output logic [7:0]    rf_dob,
  output logic          rf_src,
  output logic          stall
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic {SRC_ALU = 1'b0, SRC_MEM = 1'b1} src_e;

  logic [3:0]    r_alu_rg   [DEPTH];
  logic [DW-1:0] r_alu_data [DEPTH];
  logic [3:0]    r_mem_rg   [DEPTH];
  logic [DW-1:0] r_mem_data [DEPTH];
  logic [7:0]    r_mem_dob  [DEPTH];

  logic [CW-1:0] r_alu_cnt, r_mem_cnt;
  logic [AW-1:0] r_alu_wp, r_alu_rp, r_mem_wp, r_mem_rp;
  src_e          r_last_grant;

  logic w_alu_push, w_mem_push, w_alu_pop, w_mem_pop;

  assign alu_ready  = (r_alu_cnt != FULL);
  assign mem_ready  = (r_mem_cnt != FULL);
  assign stall      = ~alu_ready | ~mem_ready;
  assign w_alu_push = alu_valid & alu_ready;
  assign w_mem_push = mem_valid & mem_ready;

  // Grant: lone non-empty queue wins; under contention the source not granted last wins.
  always_comb begin
    w_alu_pop = 1'b0;
    w_mem_pop = 1'b0;
    if ((r_mem_cnt != '0) && ((r_alu_cnt == '0) || (r_last_grant == SRC_ALU))) begin
      w_mem_pop = 1'b1;
    end else if (r_alu_cnt != '0) begin
      w_alu_pop = 1'b1;
    end else begin
      w_alu_pop = 1'b0;
      w_mem_pop = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_alu_push) begin
      r_alu_rg[r_alu_wp]   <= alu_rg;
      r_alu_data[r_alu_wp] <= alu_data;
    end
    if (w_mem_push) begin
      r_mem_rg[r_mem_wp]   <= mem_rg;
      r_mem_data[r_mem_wp] <= mem_data;
      r_mem_dob[r_mem_wp]  <= mem_dob;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alu_cnt <= '0;
      r_mem_cnt <= '0;
      r_alu_wp  <= '0;
      r_alu_rp  <= '0;
      r_mem_wp  <= '0;
      r_mem_rp  <= '0;
    end else begin
      if (w_alu_push) r_alu_wp <= r_alu_wp + AW'(1);
      if (w_alu_pop)  r_alu_rp <= r_alu_rp + AW'(1);
      if (w_mem_push) r_mem_wp <= r_mem_wp + AW'(1);
      if (w_mem_pop)  r_mem_rp <= r_mem_rp + AW'(1);
      case ({w_alu_push, w_alu_pop})
        2'b10:   r_alu_cnt <= r_alu_cnt + CW'(1);
        2'b01:   r_alu_cnt <= r_alu_cnt - CW'(1);
        default: r_alu_cnt <= r_alu_cnt;
      endcase
      case ({w_mem_push, w_mem_pop})
        2'b10:   r_mem_cnt <= r_mem_cnt + CW'(1);
        2'b01:   r_mem_cnt <= r_mem_cnt - CW'(1);
        default: r_mem_cnt <= r_mem_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= SRC_ALU;
      rf_we        <= 1'b0;
      rf_rg        <= 4'd0;
      rf_data      <= '0;
      rf_dob       <= 8'd0;
      rf_src       <= 1'b0;
    end else begin
      rf_we <= w_alu_pop | w_mem_pop;
      if (w_mem_pop) begin
        r_last_grant <= SRC_MEM;
        rf_rg        <= r_mem_rg[r_mem_rp];
        rf_data      <= r_mem_data[r_mem_rp];
        rf_dob       <= r_mem_dob[r_mem_rp];
        rf_src       <= 1'b1;
      end else if (w_alu_pop) begin
        r_last_grant <= SRC_ALU;
        rf_rg        <= r_alu_rg[r_alu_rp];
        rf_data      <= r_alu_data[r_alu_rp];
        rf_dob       <= 8'd0;
        rf_src       <= 1'b0;
      end
    end
  end

endmodule
